spi_slave_regs: RTL and testbench

Parametrised SPI slave with a built-in register file, the next generation of the board's single-byte SPI slave. It supports configurable word width, all four SPI modes, multi-word framed transactions with a read/write command word, and auto-incrementing addressing. It sits between the STM32H7 SPI master and FPGA fabric. Register contents drive fabric controls, and a read-only status word is returned at address 0.

---
 rtl/spi_slave_regs.sv | 156 +++++++++++++++
 tb/tb_spi_slave_regs.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI slave with a framed read/write command word and an auto-incrementing register file.
// Define SPI_SLAVE_REGS_TRISTATE_EN to float MISO while the slave is deselected.
module spi_slave_regs #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCK,
    input  logic                         MOSI,
    input  logic                         SSEL,
    output logic                         MISO,
    input  logic [WIDTH-1:0]             status_in,
    output logic [WIDTH*(2**ADDR_W)-1:0] regs_q,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_done
);
    localparam int NREG  = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state, state_d;
    logic [2:0]        sck_sync, ssel_sync;
    logic [1:0]        mosi_sync;
    logic              warm, armed;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WIDTH-2:0]  rx_sr;
    logic [WIDTH-1:0]  tx_sr, rx_word, rd_word, load_word;
    logic [ADDR_W-1:0] addr;
    logic              is_read;
    logic [7:0]        frame_cnt, frame_cnt_nxt;
    logic [WIDTH-1:0]  regs [NREG];
    logic sck_rise, sck_fall, sck_lead, sck_trail, ssel_fall, ssel_rise;
    logic sck_ok, sample_ev, shift_ev, bit_last, word_done, wr_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {3{CPOL}};
            ssel_sync <= 3'b111;
            mosi_sync <= 2'b00;
            warm      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[1:0], SCK};
            ssel_sync <= {ssel_sync[1:0], SSEL};
            mosi_sync <= {mosi_sync[0], MOSI};
            warm      <= 1'b1;
            // Frames start only after SSEL has been seen high, so a reset mid-frame ignores the tail.
            armed     <= armed | (warm & ssel_sync[0]);
        end
    end

    assign sck_rise      = sck_sync[1] & ~sck_sync[2];
    assign sck_fall      = ~sck_sync[1] & sck_sync[2];
    assign sck_lead      = CPOL ? sck_fall : sck_rise;
    assign sck_trail     = CPOL ? sck_rise : sck_fall;
    assign ssel_fall     = armed & ssel_sync[2] & ~ssel_sync[1];
    assign ssel_rise     = ~ssel_sync[2] & ssel_sync[1];
    assign sck_ok        = (state != IDLE) & ~ssel_fall & ~ssel_rise;
    assign sample_ev     = sck_ok & (CPHA ? sck_trail : sck_lead);
    assign shift_ev      = sck_ok & (CPHA ? sck_lead : sck_trail);
    assign bit_last      = (bit_cnt == CNT_W'(WIDTH - 1));
    assign word_done     = sample_ev & bit_last;
    assign rx_word       = {rx_sr, mosi_sync[1]};
    assign rd_word       = (addr == '0) ? status_in : regs[addr];
    assign wr_commit     = word_done & (state == DATA) & ~is_read & (addr != '0);
    assign frame_cnt_nxt = frame_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state;
        if (ssel_rise)                        state_d = IDLE;
        else if (ssel_fall && state == IDLE)  state_d = CMD;
        else if (state == CMD && word_done)   state_d = DATA;
    end

    always_comb begin
        load_word = '0;
        case (state)
            CMD:     load_word = WIDTH'(frame_cnt);
            DATA:    if (is_read) load_word = rd_word;
            default: load_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            addr       <= '0;
            is_read    <= 1'b0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= ssel_rise & (state != IDLE);
            if (ssel_fall) begin
                frame_cnt <= frame_cnt_nxt;
                bit_cnt   <= '0;
                tx_sr     <= CPHA ? '0 : WIDTH'(frame_cnt_nxt);
            end else if (state == IDLE || ssel_rise) begin
                bit_cnt <= '0;
            end else begin
                if (sample_ev) begin
                    rx_sr   <= rx_word[WIDTH-2:0];
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                    if (bit_last) begin
                        if (state == CMD) begin
                            is_read <= rx_word[WIDTH-1];
                            addr    <= rx_word[ADDR_W-1:0];
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                // bit_cnt is zero on the first shift edge of each word: that edge loads, others shift.
                if (shift_ev) tx_sr <= (bit_cnt == '0) ? load_word : {tx_sr[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is reset because its contents drive fabric controls directly.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_stb <= wr_commit;
            if (wr_commit) begin
                regs[addr] <= rx_word;
                wr_addr    <= addr;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) regs_q[i*WIDTH +: WIDTH] = regs[i];
    end

`ifdef SPI_SLAVE_REGS_TRISTATE_EN
    assign MISO = ssel_sync[2] ? 1'bz : tx_sr[WIDTH-1];
`else
    assign MISO = ssel_sync[2] ? 1'b0 : tx_sr[WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: one instance per SPI mode, driven by a bit-level master task.
module tb_spi_slave_regs;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   sck, mosi, ssel;
    logic [7:0]   status_in;
    wire  [3:0]   miso, wr_stb_a, frame_done_a;
    wire  [127:0] regs_q_a [4];
    wire  [3:0]   wr_addr_a [4];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         wr_cnt [4] = '{default: 0};
    int         fd_cnt [4] = '{default: 0};
    logic [3:0] wr_hist [4][16];

`ifdef SPI_SLAVE_REGS_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_regs #(
            .WIDTH(8), .ADDR_W(4), .CPOL(g >= 2), .CPHA(g % 2 == 1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .SCK(sck[g]), .MOSI(mosi[g]), .SSEL(ssel[g]),
            .MISO(miso[g]), .status_in(status_in), .regs_q(regs_q_a[g]),
            .wr_stb(wr_stb_a[g]), .wr_addr(wr_addr_a[g]), .frame_done(frame_done_a[g])
        );
    end

    // Log every write strobe and frame_done pulse per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_stb_a[i] === 1'b1) begin
                wr_hist[i][wr_cnt[i] % 16] = wr_addr_a[i];
                wr_cnt[i]++;
            end
            if (frame_done_a[i] === 1'b1) fd_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master: nw bytes MSB first, the last one truncated to last_bits; keep_sel leaves SSEL low.
    task automatic spi_frame(input int m, input int nw, input logic [7:0] w0, w1, w2,
                             input int last_bits, input bit keep_sel,
                             output logic [7:0] r0, r1, r2);
        logic [7:0] tx [3];
        logic [7:0] rx [3];
        logic       cpol, cpha;
        int         nb;
        tx[0] = w0; tx[1] = w1; tx[2] = w2;
        rx[0] = '0; rx[1] = '0; rx[2] = '0;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        sck[m]  = cpol;
        ssel[m] = 1'b0;
        #80;
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? last_bits : 8;
            for (int b = 7; b > 7 - nb; b--) begin
                if (!cpha) begin
                    mosi[m] = tx[w][b]; #40;
                    rx[w][b] = miso[m];
                    sck[m] = ~cpol; #40;
                    sck[m] = cpol;
                end else begin
                    sck[m] = ~cpol;
                    mosi[m] = tx[w][b]; #40;
                    rx[w][b] = miso[m];
                    sck[m] = cpol; #40;
                end
            end
        end
        #40;
        if (!keep_sel) begin
            ssel[m] = 1'b1;
            #160;
        end
        r0 = rx[0]; r1 = rx[1]; r2 = rx[2];
    endtask

    initial begin : main
        logic [7:0] r0, r1, r2;
        int         base, fbase;

        rst_n = 1'b0; sck = 4'b1100; mosi = 4'h0; ssel = 4'hF; status_in = 8'h77;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("m%0d_rst_miso", m), miso[m], IDLE_MISO);
            check($sformatf("m%0d_rst_regs", m), regs_q_a[m], 128'h0);
            check($sformatf("m%0d_rst_wr_stb", m), wr_stb_a[m], 1'b0);
            check($sformatf("m%0d_rst_wr_addr", m), wr_addr_a[m], 4'h0);
            check($sformatf("m%0d_rst_frame_done", m), frame_done_a[m], 1'b0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Same write/read sequence in every mode.
        for (int m = 0; m < 4; m++) begin
            base = wr_cnt[m]; fbase = fd_cnt[m];
            spi_frame(m, 3, 8'h03, 8'hA5, 8'h5A, 8, 1'b0, r0, r1, r2);
            check($sformatf("m%0d_cnt1", m), r0, 8'h01);
            check($sformatf("m%0d_wr_miso", m), {r1, r2}, 16'h0000);
            check($sformatf("m%0d_reg3", m), regs_q_a[m][3*8 +: 8], 8'hA5);
            check($sformatf("m%0d_reg4", m), regs_q_a[m][4*8 +: 8], 8'h5A);
            check($sformatf("m%0d_wr_cnt", m), wr_cnt[m] - base, 2);
            check($sformatf("m%0d_wr_addr0", m), wr_hist[m][base % 16], 4'h3);
            check($sformatf("m%0d_wr_addr1", m), wr_hist[m][(base + 1) % 16], 4'h4);
            check($sformatf("m%0d_frame_done", m), fd_cnt[m] - fbase, 1);

            spi_frame(m, 2, 8'h0F, 8'hC3, 8'h00, 8, 1'b0, r0, r1, r2);
            check($sformatf("m%0d_cnt2", m), r0, 8'h02);
            check($sformatf("m%0d_reg15", m), regs_q_a[m][15*8 +: 8], 8'hC3);

            spi_frame(m, 3, 8'h8F, 8'h00, 8'h00, 8, 1'b0, r0, r1, r2);
            check($sformatf("m%0d_cnt3", m), r0, 8'h03);
            check($sformatf("m%0d_rd_reg15", m), r1, 8'hC3);
            check($sformatf("m%0d_rd_status", m), r2, 8'h77);

            spi_frame(m, 3, 8'h83, 8'h00, 8'h00, 8, 1'b0, r0, r1, r2);
            check($sformatf("m%0d_cnt4", m), r0, 8'h04);
            check($sformatf("m%0d_rd_reg3", m), r1, 8'hA5);
            check($sformatf("m%0d_rd_reg4", m), r2, 8'h5A);
            check($sformatf("m%0d_idle_miso", m), miso[m], IDLE_MISO);
        end

        // SSEL raised after 5 bits of the data word.
        base = wr_cnt[0];
        spi_frame(0, 2, 8'h05, 8'h99, 8'h00, 5, 1'b0, r0, r1, r2);
        check("abort_cnt5", r0, 8'h05);
        check("abort_reg5", regs_q_a[0][5*8 +: 8], 8'h00);
        check("abort_no_stb", wr_cnt[0] - base, 0);

        // Write to address 0 is dropped, the following word lands at address 1.
        base = wr_cnt[0];
        spi_frame(0, 3, 8'h00, 8'hFF, 8'h66, 8, 1'b0, r0, r1, r2);
        check("addr0_cnt6", r0, 8'h06);
        check("addr0_reg0", regs_q_a[0][7:0], 8'h00);
        check("addr0_reg1", regs_q_a[0][1*8 +: 8], 8'h66);
        check("addr0_stb_cnt", wr_cnt[0] - base, 1);
        check("addr0_stb_addr", wr_hist[0][base % 16], 4'h1);

        // 256 more frames bring the counter back to 6, the next shows 7.
        for (int k = 0; k < 256; k++) spi_frame(0, 1, 8'h80, 8'h00, 8'h00, 8, 1'b0, r0, r1, r2);
        check("wrap_cnt", r0, 8'h06);
        spi_frame(0, 1, 8'h80, 8'h00, 8'h00, 8, 1'b0, r0, r1, r2);
        check("wrap_next", r0, 8'h07);

        // Reset in the middle of a data word, then the rest of the frame clocks in.
        base = wr_cnt[0];
        spi_frame(0, 2, 8'h06, 8'hEE, 8'h00, 4, 1'b1, r0, r1, r2);
        rst_n = 1'b0;
        #20;
        check("midrst_regs", regs_q_a[0], 128'h0);
        check("midrst_wr_stb", wr_stb_a[0], 1'b0);
        check("midrst_wr_addr", wr_addr_a[0], 4'h0);
        check("midrst_frame_done", frame_done_a[0], 1'b0);
        check("midrst_miso", miso[0], IDLE_MISO);
        rst_n = 1'b1;
        #20;
        for (int k = 0; k < 4; k++) begin
            mosi[0] = 1'b1; #40;
            sck[0] = 1'b1; #40;
            sck[0] = 1'b0;
        end
        #40;
        ssel[0] = 1'b1;
        #160;
        check("midrst_no_stb", wr_cnt[0] - base, 0);
        check("midrst_reg6", regs_q_a[0][6*8 +: 8], 8'h00);
        spi_frame(0, 2, 8'h06, 8'hEE, 8'h00, 8, 1'b0, r0, r1, r2);
        check("postrst_cnt1", r0, 8'h01);
        check("postrst_reg6", regs_q_a[0][6*8 +: 8], 8'hEE);
        check("postrst_stb", wr_cnt[0] - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
